// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side sequencer for the UART block.
// Generates the 16x oversampling tick, walks uart_rx through OFF/SYNC/RUN
// (holding it in reset until the line has idled long enough), filters
// received bytes by error status into a first-word-fall-through FIFO, and
// keeps sticky overrun plus saturating error counters.
module uart_rx_ctrl #(
  parameter int DEPTH      = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int SYNC_TICKS = 160
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [DIV_WIDTH-1:0]       baud_div,
  input  logic                       parity_enable_cfg,
  input  logic                       rx_pin,
  output logic                       tick_16x,
  output logic                       rx_reset,
  output logic                       parity_enable,
  input  logic [7:0]                 rx_data,
  input  logic                       data_ready,
  input  logic                       parity_err,
  input  logic                       frame_err,
  output logic [7:0]                 out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overrun,
  output logic [7:0]                 parity_err_cnt,
  output logic [7:0]                 frame_err_cnt,
  input  logic                       clear_status
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(SYNC_TICKS + 1);

  typedef enum logic [1:0] {S_OFF, S_SYNC, S_RUN} state_t;

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] shadow_div_q, shadow_div_d;
  logic                 shadow_par_q, shadow_par_d;
  logic [SW-1:0]        sync_cnt_q, sync_cnt_d;
  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_sync_q, rx_sync_d;
  logic                 tick_q, tick_d;
  logic                 rx_reset_q, rx_reset_d;
  logic [AW-1:0]        wptr_q, wptr_d;
  logic [AW-1:0]        rptr_q, rptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 overrun_q, overrun_d;
  logic [7:0]           perr_cnt_q, perr_cnt_d;
  logic [7:0]           ferr_cnt_q, ferr_cnt_d;
  logic [7:0]           mem_q [DEPTH];

  logic wrap, dr, par_hit, frm_hit, good, full, pop, push;

  // Next-state logic for sequencer, baud divider, line sync and FIFO/status.
  always_comb begin
    state_d      = state_q;
    shadow_div_d = shadow_div_q;
    shadow_par_d = shadow_par_q;
    rx_meta_d    = rx_pin;
    rx_sync_d    = rx_meta_q;

    // Divider wrap is the internal tick; the port copy is one cycle later.
    wrap = (state_q != S_OFF) && (div_q == shadow_div_q);

    case (state_q)
      S_OFF: begin
        if (enable) begin
          state_d      = S_SYNC;
          shadow_div_d = baud_div;
          shadow_par_d = parity_enable_cfg;
        end
      end
      S_SYNC: begin
        if (!enable)                             state_d = S_OFF;
        else if (sync_cnt_q >= SW'(SYNC_TICKS))  state_d = S_RUN;
      end
      S_RUN: begin
        if (!enable) state_d = S_OFF;
      end
      default: state_d = S_OFF;
    endcase

    // Divider sits at 0 while OFF so every SYNC entry starts a fresh period.
    if (state_q == S_OFF || state_d == S_OFF) div_d = '0;
    else if (wrap)                            div_d = '0;
    else                                      div_d = div_q + DIV_WIDTH'(1);

    // Count consecutive idle ticks; any low sample restarts the wait.
    sync_cnt_d = '0;
    if (state_q == S_SYNC && state_d == S_SYNC) begin
      sync_cnt_d = sync_cnt_q;
      if (wrap) begin
        if (!rx_sync_q)                        sync_cnt_d = '0;
        else if (sync_cnt_q < SW'(SYNC_TICKS)) sync_cnt_d = sync_cnt_q + SW'(1);
      end
    end

    tick_d     = wrap && (state_d != S_OFF);
    rx_reset_d = (state_d != S_RUN);

    // Byte acceptance: only meaningful once uart_rx is out of reset.
    dr      = data_ready && (state_q == S_RUN);
    par_hit = dr && parity_err && shadow_par_q;
    frm_hit = dr && frame_err;
    good    = dr && !frame_err && !(parity_err && shadow_par_q);
    full    = (count_q == CW'(DEPTH));
    pop     = (count_q != '0) && out_ready;
    push    = good && (!full || pop);

    wptr_d = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Status: clear wins over a same-cycle event; counters saturate.
    if (clear_status)              overrun_d = 1'b0;
    else if (good && full && !pop) overrun_d = 1'b1;
    else                           overrun_d = overrun_q;

    if (clear_status)                      perr_cnt_d = '0;
    else if (par_hit && perr_cnt_q != '1)  perr_cnt_d = perr_cnt_q + 8'd1;
    else                                   perr_cnt_d = perr_cnt_q;

    if (clear_status)                      ferr_cnt_d = '0;
    else if (frm_hit && ferr_cnt_q != '1)  ferr_cnt_d = ferr_cnt_q + 8'd1;
    else                                   ferr_cnt_d = ferr_cnt_q;
  end

  // Control and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_OFF;
      div_q        <= '0;
      shadow_div_q <= '0;
      shadow_par_q <= 1'b0;
      sync_cnt_q   <= '0;
      rx_meta_q    <= 1'b0;
      rx_sync_q    <= 1'b0;
      tick_q       <= 1'b0;
      rx_reset_q   <= 1'b1;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      overrun_q    <= 1'b0;
      perr_cnt_q   <= '0;
      ferr_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      shadow_div_q <= shadow_div_d;
      shadow_par_q <= shadow_par_d;
      sync_cnt_q   <= sync_cnt_d;
      rx_meta_q    <= rx_meta_d;
      rx_sync_q    <= rx_sync_d;
      tick_q       <= tick_d;
      rx_reset_q   <= rx_reset_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      overrun_q    <= overrun_d;
      perr_cnt_q   <= perr_cnt_d;
      ferr_cnt_q   <= ferr_cnt_d;
    end
  end

  // FIFO storage; unreset because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= rx_data;
  end

  assign tick_16x       = tick_q;
  assign rx_reset       = rx_reset_q;
  assign parity_enable  = shadow_par_q;
  assign out_valid      = (count_q != '0);
  assign out_data       = out_valid ? mem_q[rptr_q] : 8'h00;
  assign fifo_count     = count_q;
  assign overrun        = overrun_q;
  assign parity_err_cnt = perr_cnt_q;
  assign frame_err_cnt  = ferr_cnt_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: reset, sync timing, sync restart,
// error filtering, overrun and mid-run disable.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] baud_div;
  logic        parity_enable_cfg;
  logic        rx_pin;
  logic        tick_16x, rx_reset, parity_enable;
  logic [7:0]  rx_data;
  logic        data_ready, parity_err, frame_err;
  logic [7:0]  out_data;
  logic        out_valid, out_ready;
  logic [3:0]  fifo_count;
  logic        overrun;
  logic [7:0]  parity_err_cnt, frame_err_cnt;
  logic        clear_status;

  int n_cmp = 0;
  int n_bad = 0;
  int first_tick, fall, nticks, bad_sp;
  logic [7:0] exp_d [8];

  uart_rx_ctrl #(.DEPTH(DEPTH), .DIV_WIDTH(16), .SYNC_TICKS(160)) dut (
    .clk(clk), .reset(reset), .enable(enable), .baud_div(baud_div),
    .parity_enable_cfg(parity_enable_cfg), .rx_pin(rx_pin),
    .tick_16x(tick_16x), .rx_reset(rx_reset), .parity_enable(parity_enable),
    .rx_data(rx_data), .data_ready(data_ready), .parity_err(parity_err),
    .frame_err(frame_err), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .fifo_count(fifo_count), .overrun(overrun),
    .parity_err_cnt(parity_err_cnt), .frame_err_cnt(frame_err_cnt),
    .clear_status(clear_status)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_byte(input logic [7:0] d, input logic pe, input logic fe);
    rx_data = d; parity_err = pe; frame_err = fe; data_ready = 1'b1;
    step();
    data_ready = 1'b0; parity_err = 1'b0; frame_err = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; baud_div = '0; parity_enable_cfg = 1'b0;
    rx_pin = 1'b1; rx_data = '0; data_ready = 1'b0; parity_err = 1'b0;
    frame_err = 1'b0; out_ready = 1'b0; clear_status = 1'b0;

    // Reset behaviour
    nticks = 0;
    repeat (5) begin step(); if (tick_16x) nticks++; end
    check("rst_ticks", nticks, 0);
    check("rst_rx_reset", rx_reset, 1);
    check("rst_par_en", parity_enable, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_overrun", overrun, 0);
    check("rst_perr", parity_err_cnt, 0);
    check("rst_ferr", frame_err_cnt, 0);
    reset = 1'b0;
    repeat (3) step();

    // Sync with baud_div=3; later config changes must be ignored
    baud_div = 16'd3; parity_enable_cfg = 1'b0; enable = 1'b1;
    step();
    baud_div = 16'd0; parity_enable_cfg = 1'b1;
    first_tick = -1; fall = -1; nticks = 0; bad_sp = 0;
    for (int k = 1; k <= 700 && fall < 0; k++) begin
      step();
      if (tick_16x) begin
        nticks++;
        if (first_tick < 0) first_tick = k;
        if (k % 4 != 0) bad_sp++;
      end
      if (!rx_reset) fall = k;
    end
    check("sync_first_tick", first_tick, 4);
    check("sync_tick_spacing", bad_sp, 0);
    check("sync_tick_count", nticks, 160);
    check("sync_run_cycle", fall, 641);
    check("sync_par_shadow", parity_enable, 0);

    // First byte into empty FIFO
    pulse_byte(8'h4E, 1'b0, 1'b0);
    check("byte_valid", out_valid, 1);
    check("byte_data", out_data, 8'h4E);
    check("byte_count", fifo_count, 1);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("byte_pop_valid", out_valid, 0);
    check("byte_pop_count", fifo_count, 0);

    // Sync restart with baud_div=0 (tick every cycle)
    enable = 1'b0; step();
    check("off_rx_reset", rx_reset, 1);
    check("off_tick", tick_16x, 0);
    baud_div = 16'd0; parity_enable_cfg = 1'b1; enable = 1'b1;
    step();
    parity_enable_cfg = 1'b0;
    check("rs_par_shadow", parity_enable, 1);
    repeat (100) step();
    check("rs_still_sync", rx_reset, 1);
    rx_pin = 1'b0;
    repeat (3) step();
    rx_pin = 1'b1;
    fall = -1; bad_sp = 0;
    for (int k = 1; k <= 400 && fall < 0; k++) begin
      step();
      if (!tick_16x) bad_sp++;
      if (!rx_reset) fall = k;
    end
    check("rs_tick_every_cycle", bad_sp, 0);
    check("rs_run_cycle", fall, 163);

    // Error filtering, parity enabled
    pulse_byte(8'h11, 1'b1, 1'b0);
    check("perr_cnt1", parity_err_cnt, 1);
    check("perr_ferr0", frame_err_cnt, 0);
    check("perr_fifo", fifo_count, 0);
    pulse_byte(8'h22, 1'b1, 1'b1);
    check("both_perr", parity_err_cnt, 2);
    check("both_ferr", frame_err_cnt, 1);
    check("both_fifo", fifo_count, 0);
    clear_status = 1'b1;
    pulse_byte(8'h33, 1'b1, 1'b0);
    clear_status = 1'b0;
    check("clr_perr", parity_err_cnt, 0);
    check("clr_ferr", frame_err_cnt, 0);
    check("clr_fifo", fifo_count, 0);

    // Overrun
    for (int i = 0; i < 8; i++) pulse_byte(8'hA0 + 8'(i), 1'b0, 1'b0);
    check("ovr_full_count", fifo_count, 8);
    check("ovr_head", out_data, 8'hA0);
    check("ovr_not_yet", overrun, 0);
    pulse_byte(8'hEE, 1'b0, 1'b0);
    check("ovr_set", overrun, 1);
    check("ovr_count8", fifo_count, 8);
    out_ready = 1'b1; rx_data = 8'hB8; data_ready = 1'b1;
    step();
    out_ready = 1'b0; data_ready = 1'b0;
    check("ovr_pushpop_count", fifo_count, 8);
    check("ovr_pushpop_head", out_data, 8'hA1);
    for (int i = 0; i < 7; i++) exp_d[i] = 8'hA1 + 8'(i);
    exp_d[7] = 8'hB8;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ovr_drain%0d", i), out_data, exp_d[i]);
      out_ready = 1'b1; step(); out_ready = 1'b0;
    end
    check("ovr_empty", out_valid, 0);
    check("ovr_sticky", overrun, 1);
    clear_status = 1'b1; step(); clear_status = 1'b0;
    check("ovr_cleared", overrun, 0);

    // Mid-run disable
    pulse_byte(8'h31, 1'b0, 1'b0);
    pulse_byte(8'h32, 1'b0, 1'b0);
    pulse_byte(8'h33, 1'b0, 1'b0);
    check("dis_count3", fifo_count, 3);
    enable = 1'b0; step();
    check("dis_rx_reset", rx_reset, 1);
    check("dis_tick", tick_16x, 0);
    pulse_byte(8'h99, 1'b0, 1'b0);
    check("dis_dr_ignored", fifo_count, 3);
    nticks = 0;
    repeat (4) begin step(); if (tick_16x) nticks++; end
    check("dis_no_ticks", nticks, 0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("dis_drain%0d", i), out_data, 8'h31 + 8'(i));
      out_ready = 1'b1; step(); out_ready = 1'b0;
    end
    check("dis_empty", out_valid, 0);
    check("dis_count0", fifo_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the UART block. It generates the 16x oversampling tick and sequences the `uart_rx` datapath through a disabled / line-sync / run cycle, holding it in reset until the line has been idle long enough. It filters received bytes by error status and buffers good bytes in a first-word-fall-through FIFO with a valid/ready consumer port, and it keeps sticky overrun and error-count status.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `DIV_WIDTH`, 16: width of the baud divisor.
- `SYNC_TICKS`, 160: consecutive idle (high) ticks required before RUN; 160 is 10 bit times.

- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: run request; level-sensitive.
- `baud_div` in DIV_WIDTH: clocks per tick minus 1.
- `parity_enable_cfg` in 1: parity checking request.
- `rx_pin` in 1: raw serial line, monitored for idle; asynchronous to `clk`.
- `tick_16x` out 1: one-cycle oversampling strobe to `uart_rx`.
- `rx_reset` out 1: reset to `uart_rx`.
- `parity_enable` out 1: latched parity configuration to `uart_rx`.
- `rx_data` in 8: byte from `uart_rx`.
- `data_ready` in 1: one-cycle byte-complete pulse from `uart_rx`.
- `parity_err` in 1: qualifies `data_ready`.
- `frame_err` in 1: qualifies `data_ready`.
- `out_data` out 8: FIFO head.
- `out_valid` out 1: FIFO not empty.
- `out_ready` in 1: consumer accept.
- `fifo_count` out $clog2(DEPTH)+1: current FIFO occupancy.
- `overrun` out 1: sticky flag; a good byte was dropped because the FIFO was full.
- `parity_err_cnt` out 8: saturating count of parity errors.
- `frame_err_cnt` out 8: saturating count of framing errors.
- `clear_status` in 1: clears `overrun` and both error counters.

## Operation
- FSM states are OFF, SYNC and RUN. Reset enters OFF.
- OFF → SYNC when `enable`=1.
  - On that transition, `baud_div` and `parity_enable_cfg` are copied to shadow registers.
  - Input changes outside that transition are ignored until the next OFF→SYNC.
- SYNC has a sync counter.
  - On each tick, a synchronized `rx_pin`=1 increments the counter. `rx_pin`=0 clears it.
  - When the counter reaches SYNC_TICKS, the FSM goes to RUN.
- `enable`=0 in any state → OFF on the next clock. The sync counter clears.
- Baud generator:
  - The divider counter is held at 0 in OFF.
  - It counts 0..shadow_div. At shadow_div it wraps to 0 and pulses `tick_16x` for one cycle.
  - shadow_div=0 gives a tick every cycle. shadow_div=3 gives a tick every 4 cycles.
- `rx_pin` passes through a 2-flop synchronizer before SYNC uses it.
- `rx_reset`=1 in OFF and SYNC, 0 in RUN. It is registered from the next state, so it drops in the same cycle the state becomes RUN.
- `parity_enable` = shadow parity bit.
- `data_ready` handling applies only in RUN; it is ignored in OFF/SYNC. On `data_ready`=1:
  - `frame_err`=1: byte dropped and `frame_err_cnt`+1.
  - `parity_err`=1 with `parity_enable`=1: byte dropped and `parity_err_cnt`+1.
  - If both errors are set, both counters increment.
  - Error-free byte with FIFO not full: pushed.
  - Error-free byte with FIFO full and no pop this cycle: dropped and `overrun` set.
  - Error-free byte with FIFO full and a pop this cycle: pushed; count unchanged.
- Pop when `out_valid` & `out_ready`.
- Pointers wrap modulo DEPTH.
- FIFO contents and status are retained across OFF. Only `reset` flushes the FIFO.
- Counters saturate at 255.
- `clear_status` takes priority over a same-cycle increment or set.

## Timing
- Reset values:
  - 1: `rx_reset`.
  - 0: `tick_16x`, `parity_enable`, `out_valid`, `out_data`, `fifo_count`, `overrun`, `parity_err_cnt`, `frame_err_cnt`.
  - State = OFF, all internal counters 0.
- First `tick_16x` comes shadow_div+1 cycles after the cycle that enters SYNC.
- Minimum OFF→RUN time is SYNC_TICKS×(shadow_div+1)+1 cycles with `rx_pin` steadily high. A `rx_pin` low seen after 2 cycles of synchronizer latency restarts the count.
- `data_ready` at cycle N into an empty FIFO gives `out_valid`=1 and `out_data` = byte at N+1.
- A pop at N updates `out_data` and `fifo_count` at N+1.
- `fifo_count` and `overrun` update one cycle after the causing event.

## Test plan
- Reset behaviour: hold `reset` 5 cycles → all outputs at reset values, `rx_reset`=1, no `tick_16x`.
- Sync and byte path:
  - Stimulus: `baud_div`=3, `enable`=1, line high, SYNC_TICKS=160.
  - Required: ticks every 4 cycles; RUN and `rx_reset`=0 after 641 cycles.
  - Then: `data_ready` with 0x4E and no errors → `out_valid`=1 and `out_data`=0x4E next cycle.
- Sync restart: `rx_pin` low at tick 100 of SYNC → count restarts, RUN reached 160 ticks after `rx_pin` returns high.
- Error filtering: parity_enable_cfg=1.
  - `data_ready` with `parity_err`=1 → `parity_err_cnt`=1, FIFO unchanged.
  - Then `frame_err`+`parity_err` together → both counts increment.
  - `clear_status` → all counts 0.
- Overrun:
  - 8 good bytes with `out_ready`=0 → `fifo_count`=8.
  - 9th byte → `overrun`=1, count stays 8, the 9th byte is never output.
  - A 9th byte arriving together with a pop → accepted, count stays 8.
- Mid-run disable: `enable`=0 with 3 bytes buffered → OFF and `rx_reset`=1 next cycle, ticks stop, all 3 bytes still drain in order; a `data_ready` during OFF is ignored.
